// File: rtl/ram_op_sequencer.sv
// ram_op_sequencer: shares the 64x8 lab RAM port between the user path and a FILL/SUM/SEARCH/INCR
// block engine over a wrapped address range. Define RAM_SEQ_SEARCH_EN to build the SEARCH operation.
module ram_op_sequencer (
    input  logic       clk_out,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [5:0] base,
    input  logic [5:0] len,
    input  logic [7:0] data,
    input  logic [5:0] usr_addr,
    input  logic       usr_we,
    input  logic [7:0] usr_wdata,
    input  logic [7:0] mem_rdata,
    output logic [5:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] OP_FILL   = 2'b00;
    localparam logic [1:0] OP_SUM    = 2'b01;
    localparam logic [1:0] OP_SEARCH = 2'b10;
    localparam logic [1:0] OP_INCR   = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [5:0] base_q, base_d;
    logic [5:0] len_q, len_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] result_q, result_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       opLegal;
    logic       lastWord;
    logic [5:0] engAddr;
    logic [7:0] engWdata;
    logic       engWe;
    logic [7:0] sumNext;

`ifdef RAM_SEQ_SEARCH_EN
    assign opLegal = 1'b1;
`else
    assign opLegal = (op != OP_SEARCH);
`endif

    // The 6-bit add wraps the range from address 63 back to 0.
    assign engAddr  = base_q + cnt_q;
    assign lastWord = (cnt_q == len_q);
    assign sumNext  = acc_q + mem_rdata;

    always_comb begin
        engWe    = 1'b0;
        engWdata = data_q;
        if (state_q == RUN) begin
            case (op_q)
                OP_FILL: begin
                    engWe    = 1'b1;
                    engWdata = data_q;
                end
                OP_INCR: begin
                    engWe    = 1'b1;
                    engWdata = mem_rdata + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // A low rst blocks every RAM write, so a reset mid-operation keeps only completed words.
    always_comb begin
        if (state_q == IDLE) begin
            mem_addr  = usr_addr;
            mem_we    = usr_we & rst;
            mem_wdata = usr_wdata;
        end else begin
            mem_addr  = engAddr;
            mem_we    = engWe & rst;
            mem_wdata = engWdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        base_d   = base_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        acc_d    = acc_q;
        result_d = result_q;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op;
                    base_d = base;
                    len_d  = len;
                    data_d = data;
                    cnt_d  = 6'd0;
                    acc_d  = 8'd0;
                    if (opLegal) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + 6'd1;
                if (lastWord) begin
                    state_d = DONE;
                end
                case (op_q)
                    OP_FILL: begin
                        if (lastWord) result_d = data_q;
                    end
                    OP_SUM: begin
                        acc_d = sumNext;
                        if (lastWord) result_d = sumNext;
                    end
`ifdef RAM_SEQ_SEARCH_EN
                    OP_SEARCH: begin
                        if (mem_rdata == data_q) begin
                            result_d = {2'b00, cnt_q};
                            state_d  = DONE;
                        end else if (lastWord) begin
                            result_d = 8'hFF;
                            err_d    = 1'b1;
                        end
                    end
`endif
                    OP_INCR: begin
                        if (lastWord) result_d = {2'b00, len_q};
                    end
                    default: ;
                endcase
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_out) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= OP_FILL;
            base_q   <= 6'd0;
            len_q    <= 6'd0;
            cnt_q    <= 6'd0;
            data_q   <= 8'd0;
            acc_q    <= 8'd0;
            result_q <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            base_q   <= base_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_ram_op_sequencer.sv
// tb_ram_op_sequencer: drives ram_op_sequencer against a behavioural 64x8 RAM and an operation-level
// reference model; works with RAM_SEQ_SEARCH_EN defined or undefined.
module tb_ram_op_sequencer;

    logic       clk_out = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [5:0] base = 6'd0;
    logic [5:0] len = 6'd0;
    logic [7:0] data = 8'd0;
    logic [5:0] usr_addr = 6'd0;
    logic       usr_we = 1'b0;
    logic [7:0] usr_wdata = 8'd0;
    logic [7:0] mem_rdata;
    logic [5:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] result;

    logic [7:0] ram [64];
    logic [7:0] modelRam [64];
    logic [7:0] modelResult = 8'd0;
    int         writeCount = 0;
    int         checks = 0;
    int         errors = 0;

`ifdef RAM_SEQ_SEARCH_EN
    localparam bit searchEn = 1'b1;
`else
    localparam bit searchEn = 1'b0;
`endif

    ram_op_sequencer dut (
        .clk_out(clk_out), .rst(rst), .start(start), .op(op), .base(base), .len(len), .data(data),
        .usr_addr(usr_addr), .usr_we(usr_we), .usr_wdata(usr_wdata), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .err(err), .result(result)
    );

    always #5 clk_out = ~clk_out;

    always @(posedge clk_out) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            writeCount    <= writeCount + 1;
        end
    end
    assign mem_rdata = ram[mem_addr];

    task automatic cycle();
        @(posedge clk_out);
        #1;
    endtask

    function automatic int ram_diff();
        int n = 0;
        for (int i = 0; i < 64; i++) if (ram[i] !== modelRam[i]) n++;
        return n;
    endfunction

    task automatic usr_write(input logic [5:0] a, input logic [7:0] d);
        usr_addr  = a;
        usr_wdata = d;
        usr_we    = 1'b1;
        cycle();
        usr_we       = 1'b0;
        modelRam[a]  = d;
    endtask

    // Reference model: applies a whole operation to the shadow RAM in one go.
    task automatic model_op(input logic [1:0] o, input logic [5:0] b, input logic [5:0] l,
                            input logic [7:0] d, output int expEdge, output logic [7:0] expRes,
                            output logic expErr, output int expWrites);
        int n = int'(l) + 1;
        int sum = 0;
        int a;
        expEdge   = n;
        expErr    = 1'b0;
        expWrites = 0;
        expRes    = modelResult;
        if (o == 2'b10 && !searchEn) begin
            expEdge = 0;
            expErr  = 1'b1;
            return;
        end
        case (o)
            2'b00: begin
                for (int i = 0; i < n; i++) modelRam[(int'(b) + i) % 64] = d;
                expRes    = d;
                expWrites = n;
            end
            2'b01: begin
                for (int i = 0; i < n; i++) sum += int'(modelRam[(int'(b) + i) % 64]);
                expRes = 8'(sum % 256);
            end
            2'b10: begin
                expRes = 8'hFF;
                expErr = 1'b1;
                for (int i = 0; i < n; i++) begin
                    if (modelRam[(int'(b) + i) % 64] == d) begin
                        expRes  = 8'(i);
                        expErr  = 1'b0;
                        expEdge = i + 1;
                        break;
                    end
                end
            end
            default: begin
                for (int i = 0; i < n; i++) begin
                    a = (int'(b) + i) % 64;
                    modelRam[a] = modelRam[a] + 8'd1;
                end
                expRes    = {2'b00, l};
                expWrites = n;
            end
        endcase
        modelResult = expRes;
    endtask

    // Issues one command and watches it to completion; doneEdge counts edges after the start edge.
    task automatic run_op(input logic [1:0] o, input logic [5:0] b, input logic [5:0] l,
                          input logic [7:0] d, input bit disturb, output int doneEdge,
                          output int busyCycles, output logic [7:0] res, output logic e,
                          output logic idleAfter);
        int edgeIdx = 0;
        logic [5:0] dAddr;
        doneEdge   = -1;
        busyCycles = 0;
        res        = 8'hxx;
        e          = 1'bx;
        op = o; base = b; len = l; data = d; start = 1'b1;
        cycle();
        start = 1'b0;
        while (edgeIdx <= 200) begin
            if (busy) busyCycles++;
            if (done) begin
                doneEdge = edgeIdx;
                res      = result;
                e        = err;
                break;
            end
            if (disturb && edgeIdx == 0) begin
                dAddr     = 6'(int'(b) + int'(l) + 1);
                start     = 1'b1;
                op        = 2'b00;
                data      = ~d;
                usr_addr  = dAddr;
                usr_wdata = ~modelRam[dAddr];
                usr_we    = 1'b1;
            end
            cycle();
            start  = 1'b0;
            usr_we = 1'b0;
            edgeIdx++;
        end
        cycle();
        idleAfter = !busy && !done && !err;
    endtask

    task automatic test_reset();
        rst = 1'b0; usr_we = 1'b1; usr_addr = 6'd5; usr_wdata = 8'h11;
        cycle();
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b want 0", mem_we); end
        cycle();
        usr_we = 1'b0;
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_flags got %b want 000", {busy, done, err});
        end
        checks++;
        if (result !== 8'h00) begin errors++; $display("[TB] FAIL reset_result got %h want 00", result); end
        rst = 1'b1;
        cycle();
        modelResult = 8'h00;
    endtask

    task automatic test_user_path();
        for (int i = 0; i < 64; i++) begin
            usr_addr = 6'(i); usr_wdata = 8'(i); usr_we = 1'b1;
            #1;
            if (i == 37) begin
                checks++;
                if (mem_addr !== 6'd37 || mem_we !== 1'b1 || mem_wdata !== 8'd37) begin
                    errors++;
                    $display("[TB] FAIL usr_passthru got %h/%b/%h want 25/1/25", mem_addr, mem_we, mem_wdata);
                end
            end
            cycle();
            modelRam[i] = 8'(i);
        end
        usr_we = 1'b0;
        checks++;
        if (ram_diff() != 0) begin errors++; $display("[TB] FAIL usr_preload got %0d bad words want 0", ram_diff()); end
    endtask

    task automatic test_sum();
        int eEdge, eWr, dEdge, bCyc, w0;
        logic [7:0] eRes, res;
        logic eErr, e, idle;
        w0 = writeCount;
        model_op(2'b01, 6'd0, 6'd63, 8'h00, eEdge, eRes, eErr, eWr);
        run_op(2'b01, 6'd0, 6'd63, 8'h00, 1'b0, dEdge, bCyc, res, e, idle);
        checks++;
        if (res !== 8'hE0 || e !== 1'b0) begin errors++; $display("[TB] FAIL sum_result got %h/%b want E0/0", res, e); end
        checks++;
        if (dEdge != 64) begin errors++; $display("[TB] FAIL sum_latency got %0d want 64", dEdge); end
        checks++;
        if (writeCount != w0) begin errors++; $display("[TB] FAIL sum_writes got %0d want 0", writeCount - w0); end
        checks++;
        if (!idle) begin errors++; $display("[TB] FAIL sum_idle got busy/done still set want idle"); end
    endtask

    task automatic test_search();
        int eEdge, eWr, dEdge, bCyc, w0;
        logic [7:0] eRes, res;
        logic eErr, e, idle;
        logic [7:0] keys [2];
        keys[0] = 8'd15;
        keys[1] = 8'hC8;
        for (int k = 0; k < 2; k++) begin
            w0 = writeCount;
            model_op(2'b10, 6'd10, 6'd20, keys[k], eEdge, eRes, eErr, eWr);
            run_op(2'b10, 6'd10, 6'd20, keys[k], 1'b0, dEdge, bCyc, res, e, idle);
            checks++;
            if (res !== eRes || e !== eErr || dEdge != eEdge || bCyc != eEdge + 1) begin
                errors++;
                $display("[TB] FAIL search_%0d got res=%h err=%b edge=%0d busy=%0d want %h %b %0d %0d",
                         k, res, e, dEdge, bCyc, eRes, eErr, eEdge, eEdge + 1);
            end
            checks++;
            if (writeCount != w0 || ram_diff() != 0) begin
                errors++; $display("[TB] FAIL search_ram_%0d got writes=%0d want 0", k, writeCount - w0);
            end
        end
`ifdef RAM_SEQ_SEARCH_EN
        checks++;
        if (modelResult !== 8'hFF) begin errors++; $display("[TB] FAIL search_nomatch_model got %h want FF", modelResult); end
`else
        checks++;
        if (res !== 8'hE0 || e !== 1'b1 || dEdge != 0) begin
            errors++; $display("[TB] FAIL search_disabled got %h/%b/%0d want E0/1/0", res, e, dEdge);
        end
`endif
    endtask

    task automatic test_fill();
        int eEdge, eWr, dEdge, bCyc, w0;
        logic [7:0] eRes, res;
        logic eErr, e, idle;
        w0 = writeCount;
        model_op(2'b00, 6'd60, 6'd7, 8'hA5, eEdge, eRes, eErr, eWr);
        run_op(2'b00, 6'd60, 6'd7, 8'hA5, 1'b0, dEdge, bCyc, res, e, idle);
        checks++;
        if (res !== 8'hA5 || e !== 1'b0 || dEdge != 8) begin
            errors++; $display("[TB] FAIL fill_done got %h/%b/%0d want A5/0/8", res, e, dEdge);
        end
        checks++;
        if (ram[63] !== 8'hA5 || ram[3] !== 8'hA5 || ram[4] !== 8'd4 || ram[59] !== 8'd59) begin
            errors++; $display("[TB] FAIL fill_wrap got %h %h %h %h want A5 A5 04 3b", ram[63], ram[3], ram[4], ram[59]);
        end
        checks++;
        if (ram_diff() != 0 || writeCount - w0 != eWr) begin
            errors++; $display("[TB] FAIL fill_ram got %0d bad words, %0d writes want 0, %0d", ram_diff(), writeCount - w0, eWr);
        end
    endtask

    task automatic test_incr_busy();
        int eEdge, eWr, dEdge, bCyc, w0;
        logic [7:0] eRes, res;
        logic eErr, e, idle;
        usr_write(6'd20, 8'hFF);
        w0 = writeCount;
        model_op(2'b11, 6'd20, 6'd0, 8'h00, eEdge, eRes, eErr, eWr);
        run_op(2'b11, 6'd20, 6'd0, 8'h00, 1'b1, dEdge, bCyc, res, e, idle);
        checks++;
        if (ram[20] !== 8'h00) begin errors++; $display("[TB] FAIL incr_wrap got %h want 00", ram[20]); end
        checks++;
        if (res !== 8'h00 || e !== 1'b0 || dEdge != 1 || bCyc != 2) begin
            errors++; $display("[TB] FAIL incr_done got %h/%b/%0d/%0d want 00/0/1/2", res, e, dEdge, bCyc);
        end
        checks++;
        if (!idle || ram_diff() != 0 || writeCount - w0 != 1) begin
            errors++; $display("[TB] FAIL incr_busy_ignore got idle=%b bad=%0d writes=%0d want 1/0/1", idle, ram_diff(), writeCount - w0);
        end
    endtask

    task automatic test_random();
        int eEdge, eWr, dEdge, bCyc, w0;
        logic [7:0] eRes, res, d;
        logic eErr, e, idle;
        logic [1:0] o;
        logic [5:0] b, l;
        for (int i = 0; i < 64; i++) usr_write(6'(i), 8'($urandom));
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) usr_write(6'($urandom), 8'($urandom));
            o = 2'($urandom);
            b = 6'($urandom);
            l = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 9));
            d = ($urandom_range(0, 1) == 1) ? modelRam[6'(int'(b) + $urandom_range(0, int'(l)))] : 8'($urandom);
            w0 = writeCount;
            model_op(o, b, l, d, eEdge, eRes, eErr, eWr);
            run_op(o, b, l, d, t[0], dEdge, bCyc, res, e, idle);
            checks++;
            if (res !== eRes || e !== eErr || dEdge != eEdge || bCyc != eEdge + 1 || !idle) begin
                errors++;
                $display("[TB] FAIL rand_%0d op=%0d got res=%h err=%b edge=%0d busy=%0d idle=%b want %h %b %0d %0d 1",
                         t, o, res, e, dEdge, bCyc, idle, eRes, eErr, eEdge, eEdge + 1);
            end
            checks++;
            if (ram_diff() != 0 || writeCount - w0 != eWr) begin
                errors++;
                $display("[TB] FAIL rand_ram_%0d got %0d bad words, %0d writes want 0, %0d", t, ram_diff(), writeCount - w0, eWr);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int w0;
        for (int i = 0; i < 16; i++) usr_write(6'(i), 8'(i));
        w0 = writeCount;
        op = 2'b00; base = 6'd0; len = 6'd15; data = 8'h3C; start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL midrun_we got %b want 0", mem_we); end
        cycle();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
            errors++; $display("[TB] FAIL midrun_state got busy=%b done=%b res=%h want 0 0 00", busy, done, result);
        end
        modelRam[0] = 8'h3C;
        modelRam[1] = 8'h3C;
        modelResult = 8'h00;
        checks++;
        if (ram_diff() != 0 || writeCount - w0 != 2) begin
            errors++; $display("[TB] FAIL midrun_ram got %0d bad words, %0d writes want 0, 2", ram_diff(), writeCount - w0);
        end
        rst = 1'b1;
        cycle();
        usr_write(6'd40, 8'h77);
        checks++;
        if (ram[40] !== 8'h77) begin errors++; $display("[TB] FAIL midrun_usr got %h want 77", ram[40]); end
    endtask

    initial begin
        test_reset();
        test_user_path();
        test_sum();
        test_search();
        test_fill();
        test_incr_busy();
        test_random();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
